out_port_buffer: RTL and testbench

- Receiving end of the processor OUT port.
- Captures each 16-bit word the processor drives on outPortData while outSignalEn is high, queues it in a small FIFO, and hands it to an external consumer over a valid/ready handshake.
- Instantiated beside processor in the top-level controller. It decouples OUT instruction timing from a slow peripheral and reports overflow back to software.

---
 rtl/out_port_buffer.sv | 95 +++++++++
 tb/tb_out_port_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/out_port_buffer.sv
// Receiving end of the processor OUT port: a first-word-fall-through FIFO drained over valid/ready.
// Optional drain interrupt output irq is built only when OUT_PORT_IRQ_EN is defined.
module out_port_buffer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_en,
  output logic [DATA_WIDTH-1:0] ext_data,
  output logic                  ext_valid,
  input  logic                  ext_ready,
  output logic                  full,
  output logic [PTR_W:0]        count,
  output logic                  overflow,
  input  logic                  clr_overflow
`ifdef OUT_PORT_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Head word is exposed straight from storage; a fresh push is only visible next cycle.
  assign ext_data  = mem[rd_ptr];
  assign ext_valid = (count != '0);
  assign full      = (count == DEPTH_CNT);

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop  = ext_valid && ext_ready;
  assign push = out_en && (!full || pop);
  assign drop = out_en && !push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= out_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef OUT_PORT_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= pop && !push && (count == (PTR_W+1)'(1));
    end
  end
`endif

endmodule

// File: tb/tb_out_port_buffer.sv
// Bench for out_port_buffer: directed scenarios plus random traffic checked against a queue model.
module tb_out_port_buffer;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] out_data;
  logic          out_en;
  logic [DW-1:0] ext_data;
  logic          ext_valid;
  logic          ext_ready;
  logic          full;
  logic [PW:0]   count;
  logic          overflow;
  logic          clr_overflow;
`ifdef OUT_PORT_IRQ_EN
  logic          irq;
`endif

  out_port_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .out_data     (out_data),
    .out_en       (out_en),
    .ext_data     (ext_data),
    .ext_valid    (ext_valid),
    .ext_ready    (ext_ready),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef OUT_PORT_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  int            nvec = 0;
  int            nerr = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] rx[$];
  bit            m_ovf;
  bit            m_irq;
  bit            prev_stall;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf      = 1'b0;
    m_irq      = 1'b0;
    prev_stall = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the state-only outputs, clock, then advance the model.
  task automatic step(input bit en, input logic [DW-1:0] d, input bit rdy, input bit clr);
    bit do_pop, do_push;
    int sz;
    out_en       = en;
    out_data     = d;
    ext_ready    = rdy;
    clr_overflow = clr;
    #1;
    sz = mq.size();
    chk("count", 32'(count), 32'(sz));
    chk("ext_valid", 32'(ext_valid), 32'(sz != 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (sz != 0) chk("ext_data", 32'(ext_data), 32'(mq[0]));
    if (prev_stall) chk("stall_hold", 32'(ext_data), 32'(prev_data));
`ifdef OUT_PORT_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
    do_pop  = (sz != 0) && rdy;
    do_push = en && ((sz < DEPTH) || do_pop);
    if (do_pop) rx.push_back(ext_data);
    prev_stall = (sz != 0) && !rdy;
    prev_data  = ext_data;
    @(posedge clk);
    m_irq = do_pop && !do_push && (sz == 1);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(d);
    if (en && !do_push) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
  endtask

  initial begin
    logic [DW-1:0] exp3 [4];
    exp3 = '{16'h2222, 16'h3333, 16'h4444, 16'hAAAA};
    reset = 1'b0; out_en = 1'b0; out_data = '0; ext_ready = 1'b0; clr_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("reset_data", 32'(ext_data), 32'h0);
    step(0, '0, 0, 0);

    // Reset while holding three words
    step(1, 16'h0A01, 0, 0);
    step(1, 16'h0A02, 0, 0);
    step(1, 16'h0A03, 0, 0);
    reset = 1'b0;
    #2;
    chk("async_count", 32'(count), 32'h0);
    chk("async_valid", 32'(ext_valid), 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    step(0, '0, 0, 0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(ext_valid), 32'h0);
    chk("rst_data", 32'(ext_data), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    // Fill to full, then overflow
    step(1, 16'h1111, 0, 0);
    step(1, 16'h2222, 0, 0);
    step(1, 16'h3333, 0, 0);
    step(1, 16'h4444, 0, 0);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(count), 32'h4);
    chk("fill_head", 32'(ext_data), 32'h1111);
    step(1, 16'h5555, 0, 0);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_count", 32'(count), 32'h4);

    // Full with simultaneous pop and push
    step(1, 16'hAAAA, 1, 0);
    chk("fullpp_count", 32'(count), 32'h4);
    rx.delete();
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    chk("drain_len", 32'(rx.size()), 32'h4);
    for (int i = 0; i < 4 && i < rx.size(); i++) chk("drain_order", 32'(rx[i]), 32'(exp3[i]));

    // Clear racing with a new drop: set wins
    for (int i = 0; i < 4; i++) step(1, DW'(16'h0B00 + i), 0, 0);
    step(1, 16'h0BFF, 0, 1);
    chk("clr_vs_drop", 32'(overflow), 32'h1);
    step(0, '0, 0, 1);
    chk("clr_alone", 32'(overflow), 32'h0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

    // Streaming with a toggling consumer
    rx.delete();
    for (int i = 0; i < 8; i++) step(1, DW'(i + 1), (i % 2) == 1, 0);
    for (int i = 0; i < 12; i++) step(0, '0, (i % 2) == 0, 0);
    chk("stream_len", 32'(rx.size()), 32'h8);
    for (int i = 0; i < 8 && i < rx.size(); i++) chk("stream_order", 32'(rx[i]), 32'(i + 1));
    chk("stream_ovf", 32'(overflow), 32'h0);

    // Drain pulse and its suppression by a simultaneous push
    step(1, 16'h00FF, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
`ifdef OUT_PORT_IRQ_EN
    chk("irq_gone", 32'(irq), 32'h0);
`endif
    step(1, 16'h0077, 0, 0);
    step(1, 16'h0078, 1, 0);
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 9) == 0);
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0);
    chk("final_empty", 32'(count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end
endmodule
